pe_mac_acc: RTL and testbench

PE_MAC_ACC -- requirements
Module: pe_mac_acc

---
 rtl/pe_mac_acc.sv | 133 +++++++++++++
 tb/tb_pe_mac_acc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_acc.sv
// ---------------------------------------------------------------------------
// pe_mac_acc
// Systolic-array processing element with a saturating multiply-accumulate
// and a drain register chain for reading results out of the array.
//
// Parameters
//   DATA_W  operand width
//   ACC_W   accumulator width, 2*DATA_W <= ACC_W <= 48
//   SIGNED  1 = two's complement operands/accumulator, 0 = unsigned
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     in_a/in_b valid this cycle
//   in_a, in_b   west / north operands
//   acc_clear    start a new tile (discard the accumulator)
//   drain_load   copy the accumulator into the drain register and restart
//   drain_shift  shift the drain chain by one PE (in_c -> out_c)
//   in_c         drain chain input from the upstream PE
//   out_valid    registered in_valid
//   out_a, out_b registered operands passed east / south
//   out_c        drain register passed to the downstream PE
//   ovf          sticky saturation flag for the current tile
// ---------------------------------------------------------------------------
module pe_mac_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              acc_clear,
  input  logic              drain_load,
  input  logic              drain_shift,
  input  logic [ACC_W-1:0]  in_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ACC_W-1:0]  out_c,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam bit IS_SIGNED = (SIGNED != 0);

  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  acc_base;
  logic [SUM_W-1:0]  sum;
  logic [ACC_W-1:0]  sat_val;
  logic              sat_flag;
  logic              start_new;

  // Saturate an ACC_W+1 bit sum to the ACC_W range. The extra bit is the
  // true sign (signed) or carry (unsigned), so overflow is detected from it.
  function automatic logic [ACC_W:0] sat(input logic [SUM_W-1:0] s);
    logic [ACC_W:0] r;
    r = {1'b0, s[ACC_W-1:0]};
    if (IS_SIGNED) begin
      if (s[ACC_W] != s[ACC_W-1]) begin
        r = s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                     : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      if (s[ACC_W]) begin
        r = {1'b1, {ACC_W{1'b1}}};
      end
    end
    return r;
  endfunction

  // Extending both operands to the product width before multiplying makes
  // the low PROD_W bits of a single multiplier correct for both signed and
  // unsigned operands.
  always_comb begin
    a_ext = IS_SIGNED ? {{DATA_W{in_a[DATA_W-1]}}, in_a} : {{DATA_W{1'b0}}, in_a};
    b_ext = IS_SIGNED ? {{DATA_W{in_b[DATA_W-1]}}, in_b} : {{DATA_W{1'b0}}, in_b};
    prod  = a_ext * b_ext;
    prod_ext = {{(SUM_W-PROD_W){IS_SIGNED & prod[PROD_W-1]}}, prod};
  end

  // Clear and drain both restart the tile, so the incoming product is added
  // to zero instead of the old accumulator; this keeps the pipeline bubble-free.
  always_comb begin
    start_new = acc_clear | drain_load;
    acc_base  = start_new ? '0 : {IS_SIGNED & acc[ACC_W-1], acc};
    sum       = acc_base + prod_ext;
    {sat_flag, sat_val} = sat(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a <= in_a;
        out_b <= in_b;
      end

      // The drain register captures the pre-edge accumulator and has
      // priority over the chain shift.
      if (drain_load) begin
        out_c <= acc;
      end else if (drain_shift) begin
        out_c <= in_c;
      end

      if (start_new) begin
        acc <= in_valid ? sat_val : '0;
        ovf <= 1'b0;
      end else if (in_valid) begin
        acc <= sat_val;
        if (sat_flag) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_acc
// Self-checking bench for pe_mac_acc. Three instances share one set of
// inputs: the default signed 8/24 PE (table-driven with a scoreboard queue),
// a signed 8/16 PE (saturation in both directions) and an unsigned 8/24 PE.
// ---------------------------------------------------------------------------
module tb_pe_mac_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        acc_clear;
  logic        drain_load;
  logic        drain_shift;
  logic [23:0] in_c;

  logic        s_valid, n_valid, u_valid;
  logic [7:0]  s_a, s_b, n_a, n_b, u_a, u_b;
  logic [23:0] s_c, u_c;
  logic [15:0] n_c;
  logic        s_ovf, n_ovf, u_ovf;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        clr;
    logic        dl;
    logic        ds;
    logic [23:0] c;
    logic        exp_v;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] exp_c;
    logic        exp_ovf;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [23:0] c;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[18];

  pe_mac_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .acc_clear(acc_clear), .drain_load(drain_load), .drain_shift(drain_shift),
    .in_c(in_c), .out_valid(s_valid), .out_a(s_a), .out_b(s_b),
    .out_c(s_c), .ovf(s_ovf)
  );

  pe_mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .acc_clear(acc_clear), .drain_load(drain_load), .drain_shift(drain_shift),
    .in_c(in_c[15:0]), .out_valid(n_valid), .out_a(n_a), .out_b(n_b),
    .out_c(n_c), .ovf(n_ovf)
  );

  pe_mac_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .acc_clear(acc_clear), .drain_load(drain_load), .drain_shift(drain_shift),
    .in_c(in_c), .out_valid(u_valid), .out_a(u_a), .out_b(u_b),
    .out_c(u_c), .ovf(u_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then wait for the edge and settle.
  task automatic drive(input logic r, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic clr, input logic dl,
                       input logic ds, input logic [23:0] c);
    rst = r; in_valid = v; in_a = a; in_b = b;
    acc_clear = clr; drain_load = dl; drain_shift = ds; in_c = c;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t t);
    exp_t e;
    e.v = t.exp_v; e.a = t.exp_a; e.b = t.exp_b; e.c = t.exp_c; e.ovf = t.exp_ovf;
    exp_q.push_back(e);
    drive(t.rst, t.v, t.a, t.b, t.clr, t.dl, t.ds, t.c);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    string tag;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty row %0d: got 0 entries, expected 1", idx);
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("row%0d", idx);
    cmp({tag, ".out_valid"}, {31'b0, s_valid}, {31'b0, e.v});
    cmp({tag, ".out_a"}, {24'b0, s_a}, {24'b0, e.a});
    cmp({tag, ".out_b"}, {24'b0, s_b}, {24'b0, e.b});
    cmp({tag, ".out_c"}, {8'b0, s_c}, {8'b0, e.c});
    cmp({tag, ".ovf"}, {31'b0, s_ovf}, {31'b0, e.ovf});
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    acc_clear = 1'b0; drain_load = 1'b0; drain_shift = 1'b0; in_c = '0;

    //         rst  v    a      b      clr  dl   ds   in_c     ev   ea     eb     ec           eovf
    vecs[0]  = {1'b1,1'b1,8'h05,8'h05,1'b0,1'b0,1'b0,24'd0,   1'b0,8'h00,8'h00,24'h000000,1'b0};
    vecs[1]  = {1'b0,1'b1,8'h03,8'h04,1'b1,1'b0,1'b0,24'd0,   1'b1,8'h03,8'h04,24'h000000,1'b0};
    vecs[2]  = {1'b0,1'b1,8'hFE,8'h05,1'b0,1'b0,1'b0,24'd0,   1'b1,8'hFE,8'h05,24'h000000,1'b0};
    vecs[3]  = {1'b0,1'b0,8'h09,8'h09,1'b0,1'b1,1'b0,24'd0,   1'b0,8'hFE,8'h05,24'h000002,1'b0};
    vecs[4]  = {1'b0,1'b1,8'h07,8'h01,1'b1,1'b0,1'b0,24'd0,   1'b1,8'h07,8'h01,24'h000002,1'b0};
    vecs[5]  = {1'b0,1'b1,8'h01,8'h01,1'b0,1'b1,1'b0,24'd0,   1'b1,8'h01,8'h01,24'h000007,1'b0};
    vecs[6]  = {1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b1,24'd99,  1'b0,8'h01,8'h01,24'd99,    1'b0};
    vecs[7]  = {1'b0,1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,24'd0,   1'b0,8'h01,8'h01,24'h000001,1'b0};
    vecs[8]  = {1'b0,1'b1,8'h06,8'hFD,1'b0,1'b0,1'b0,24'd0,   1'b1,8'h06,8'hFD,24'h000001,1'b0};
    vecs[9]  = {1'b0,1'b0,8'h00,8'h00,1'b0,1'b1,1'b1,24'd55,  1'b0,8'h06,8'hFD,24'hFFFFEE,1'b0};
    vecs[10] = {1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,24'd77,  1'b0,8'h06,8'hFD,24'hFFFFEE,1'b0};
    vecs[11] = {1'b0,1'b1,8'h0A,8'h0A,1'b0,1'b0,1'b0,24'd0,   1'b1,8'h0A,8'h0A,24'hFFFFEE,1'b0};
    vecs[12] = {1'b1,1'b1,8'h04,8'h04,1'b0,1'b1,1'b1,24'd5,   1'b0,8'h00,8'h00,24'h000000,1'b0};
    vecs[13] = {1'b0,1'b1,8'h02,8'h03,1'b0,1'b0,1'b0,24'd0,   1'b1,8'h02,8'h03,24'h000000,1'b0};
    vecs[14] = {1'b0,1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,24'd0,   1'b0,8'h02,8'h03,24'h000006,1'b0};
    vecs[15] = {1'b0,1'b1,8'h05,8'h05,1'b0,1'b0,1'b0,24'd0,   1'b1,8'h05,8'h05,24'h000006,1'b0};
    vecs[16] = {1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,24'd0,   1'b0,8'h05,8'h05,24'h000006,1'b0};
    vecs[17] = {1'b0,1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,24'd0,   1'b0,8'h05,8'h05,24'h000000,1'b0};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Signed 16-bit accumulator: positive then negative saturation.
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("sat16.reset_ovf", {31'b0, n_ovf}, 32'd0);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 24'd0);
    cmp("sat16.c1_ovf", {31'b0, n_ovf}, 32'd0);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("sat16.c2_ovf", {31'b0, n_ovf}, 32'd1);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("sat16.c3_ovf", {31'b0, n_ovf}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 24'd0);
    cmp("sat16.max_out_c", {16'b0, n_c}, 32'h7FFF);
    cmp("sat16.drain_ovf", {31'b0, n_ovf}, 32'd0);
    drive(1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("sat16.neg2_ovf", {31'b0, n_ovf}, 32'd0);
    drive(1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("sat16.neg3_ovf", {31'b0, n_ovf}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 24'd0);
    cmp("sat16.min_out_c", {16'b0, n_c}, 32'h8000);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("sat16.resat_ovf", {31'b0, n_ovf}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 24'd0);
    cmp("sat16.clear_ovf", {31'b0, n_ovf}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 24'd0);
    cmp("sat16.clear_out_c", {16'b0, n_c}, 32'd0);

    // Unsigned accumulator: 255*255 twice, then run up to the 24-bit ceiling.
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 24'd0);
    cmp("uns.out_c", {8'b0, u_c}, 32'd130050);
    cmp("uns.ovf", {31'b0, u_ovf}, 32'd0);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 24'd0);
    for (int i = 1; i < 258; i++) begin
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 24'd0);
    end
    cmp("uns.below_max_ovf", {31'b0, u_ovf}, 32'd0);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 24'd0);
    cmp("uns.at_max_ovf", {31'b0, u_ovf}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 24'd0);
    cmp("uns.max_out_c", {8'b0, u_c}, 32'hFFFFFF);
    cmp("uns.drain_ovf", {31'b0, u_ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
